// File: rtl/decode_stage.sv
// Purpose : RV32I instruction decode stage; splits a raw instruction word into fields,
//           immediate and format class, and counts legal instructions delivered downstream.
// Latency : 1 cycle from accept (in_valid && in_ready) to out_valid.
// Backpressure: single output register; in_ready = (!out_valid || out_ready) && !flush, so a
//           stalled bundle blocks new input and a simultaneous drain+accept gives 1/cycle.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready           input handshake; in_instr (32b), in_pc (XLEN)
//   flush                       drops the held bundle, blocks accept for that cycle
//   out_valid/out_ready         output handshake
//   out_opcode..out_funct7      decoded register/function fields (unused ones forced to 0)
//   out_imm, out_pc             sign-extended immediate and PC of the held instruction
//   out_fmt, out_illegal        format class (R0 I1 S2 B3 U4 J5 none7) and illegal flag
//   dec_count                   wrapping count of legal bundles transferred out
module decode_stage #(
    parameter int XLEN  = 32,   // 32 or 64
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_pc,
    output logic [2:0]       out_fmt,
    output logic [0:0]       out_illegal,
    output logic [CNT_W-1:0] dec_count
);

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    // Decoded bundle as held in the output register.
    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [2:0]      fmt;
        logic            illegal;
    } bundle_t;

    logic [2:0]        w_fmt;
    logic signed [31:0] w_imm32;
    bundle_t           w_bundle;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_xfer;

    bundle_t           r_bundle;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_dec_count;

    // Format class from the 7-bit major opcode. Every legal opcode ends in 2'b11,
    // so compressed encodings fall through to FMT_NONE without a separate test.
    always_comb begin
        w_fmt = FMT_NONE;
        case (in_instr[6:0])
            7'b0110011:                         w_fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b0001111, 7'b1110011:             w_fmt = FMT_I;
            7'b0100011:                         w_fmt = FMT_S;
            7'b1100011:                         w_fmt = FMT_B;
            7'b0110111, 7'b0010111:             w_fmt = FMT_U;
            7'b1101111:                         w_fmt = FMT_J;
            default:                            w_fmt = FMT_NONE;
        endcase
    end

    // 32-bit immediate per format; widened to XLEN by signed cast below.
    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            FMT_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: w_imm32 = {in_instr[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Field gating: a field is only passed through for formats that define it,
    // so downstream never sees stray register numbers from immediate bits.
    // The opcode is always passed through, even for illegal words, so the
    // consumer can report which opcode was rejected.
    always_comb begin
        w_bundle         = '0;
        w_bundle.opcode  = in_instr[6:0];
        w_bundle.pc      = in_pc;
        w_bundle.fmt     = w_fmt;
        w_bundle.illegal = (w_fmt == FMT_NONE);
        if (w_fmt == FMT_R || w_fmt == FMT_I || w_fmt == FMT_U || w_fmt == FMT_J) begin
            w_bundle.rd = in_instr[11:7];
        end
        if (w_fmt == FMT_R || w_fmt == FMT_I || w_fmt == FMT_S || w_fmt == FMT_B) begin
            w_bundle.rs1    = in_instr[19:15];
            w_bundle.funct3 = in_instr[14:12];
        end
        if (w_fmt == FMT_R || w_fmt == FMT_S || w_fmt == FMT_B) begin
            w_bundle.rs2 = in_instr[24:20];
        end
        if (w_fmt == FMT_R) begin
            w_bundle.funct7 = in_instr[31:25];
        end
        w_bundle.imm = XLEN'(w_imm32);
    end

    // Flush dominates: no accept and no transfer is recognised while it is high.
    assign w_in_ready = (!r_out_valid || out_ready) && !flush;
    assign w_accept   = in_valid && w_in_ready;
    assign w_xfer     = r_out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_dec_count  <= '0;
            r_bundle     <= '0;
            r_bundle.fmt <= FMT_NONE;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_bundle    <= w_bundle;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_xfer && !r_bundle.illegal) begin
                r_dec_count <= r_dec_count + CNT_W'(1);
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_opcode  = r_bundle.opcode;
    assign out_rd      = r_bundle.rd;
    assign out_rs1     = r_bundle.rs1;
    assign out_rs2     = r_bundle.rs2;
    assign out_funct3  = r_bundle.funct3;
    assign out_funct7  = r_bundle.funct7;
    assign out_imm     = r_bundle.imm;
    assign out_pc      = r_bundle.pc;
    assign out_fmt     = r_bundle.fmt;
    assign out_illegal = r_bundle.illegal;
    assign dec_count   = r_dec_count;

endmodule

// File: tb/tb_decode_stage.sv
// Purpose : self-checking bench for decode_stage (XLEN=32/CNT_W=16 and XLEN=64/CNT_W=4 copies).
// Latency : n/a (testbench).
// Backpressure: drives random out_ready/flush against a one-entry reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc64;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [6:0]  a_op, b_op, a_f7, b_f7;
    logic [4:0]  a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
    logic [2:0]  a_f3, b_f3, a_fmt, b_fmt;
    logic [31:0] a_imm, a_pc;
    logic [63:0] b_imm, b_pc;
    logic [0:0]  a_ill, b_ill;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc64[31:0]), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_opcode(a_op), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
        .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm), .out_pc(a_pc),
        .out_fmt(a_fmt), .out_illegal(a_ill), .dec_count(a_cnt));

    decode_stage #(.XLEN(64), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc64), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_opcode(b_op), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
        .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_imm), .out_pc(b_pc),
        .out_fmt(b_fmt), .out_illegal(b_ill), .dec_count(b_cnt));

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm, pc;
        logic [2:0]  fmt;
        logic        ill;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    int          checks = 0;
    int          failures = 0;

    // Reference model state: one held bundle, plus an unbounded transfer count.
    bit          m_vld = 1'b0;
    bit          m_fresh = 1'b1;
    logic [31:0] m_instr = '0;
    logic [63:0] m_pc = '0;
    int unsigned m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Decode straight from the ISA rules using sign-aware 64-bit arithmetic.
    function automatic obs_t ref_decode(input logic [31:0] w, input logic [63:0] pc);
        obs_t   d;
        longint s, sgn;
        s   = longint'($signed(w));
        sgn = s >>> 31;
        d = '{op: w[6:0], rd: 5'd0, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7: 7'd0,
              imm: 64'd0, pc: pc, fmt: 3'd7, ill: 1'b1};
        case (w[6:0])
            7'h33:                               d.fmt = 3'd0;
            7'h13, 7'h03, 7'h67, 7'h0F, 7'h73:   d.fmt = 3'd1;
            7'h23:                               d.fmt = 3'd2;
            7'h63:                               d.fmt = 3'd3;
            7'h37, 7'h17:                        d.fmt = 3'd4;
            7'h6F:                               d.fmt = 3'd5;
            default:                             return d;
        endcase
        d.ill = 1'b0;
        if (d.fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) d.rd = w[11:7];
        if (d.fmt inside {3'd0, 3'd1, 3'd2, 3'd3}) begin
            d.rs1 = w[19:15];
            d.f3  = w[14:12];
        end
        if (d.fmt inside {3'd0, 3'd2, 3'd3}) d.rs2 = w[24:20];
        if (d.fmt == 3'd0) d.f7 = w[31:25];
        case (d.fmt)
            3'd1: d.imm = s >>> 20;
            3'd2: d.imm = ((s >>> 25) << 5) | longint'(w[11:7]);
            3'd3: d.imm = (sgn << 12) | (longint'(w[7]) << 11) | (longint'(w[30:25]) << 5)
                          | (longint'(w[11:8]) << 1);
            3'd4: d.imm = s & ~longint'(12'hFFF);
            3'd5: d.imm = (sgn << 20) | (longint'(w[19:12]) << 12) | (longint'(w[20]) << 11)
                          | (longint'(w[30:21]) << 1);
            default: d.imm = 64'd0;
        endcase
        return d;
    endfunction

    function automatic obs_t narrow(input obs_t d);
        obs_t n;
        n = d;
        n.imm = {32'd0, d.imm[31:0]};
        n.pc  = {32'd0, d.pc[31:0]};
        return n;
    endfunction

    function automatic obs_t obs_a();
        obs_t o;
        o = '{op: a_op, rd: a_rd, rs1: a_rs1, rs2: a_rs2, f3: a_f3, f7: a_f7,
              imm: {32'd0, a_imm}, pc: {32'd0, a_pc}, fmt: a_fmt, ill: a_ill[0]};
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o = '{op: b_op, rd: b_rd, rs1: b_rs1, rs2: b_rs2, f3: b_f3, f7: b_f7,
              imm: b_imm, pc: b_pc, fmt: b_fmt, ill: b_ill[0]};
        return o;
    endfunction

    task automatic cmp_obs(input string t, input obs_t act, input obs_t exp);
        chk({t, ".opcode"},  64'(act.op),  64'(exp.op));
        chk({t, ".rd"},      64'(act.rd),  64'(exp.rd));
        chk({t, ".rs1"},     64'(act.rs1), 64'(exp.rs1));
        chk({t, ".rs2"},     64'(act.rs2), 64'(exp.rs2));
        chk({t, ".funct3"},  64'(act.f3),  64'(exp.f3));
        chk({t, ".funct7"},  64'(act.f7),  64'(exp.f7));
        chk({t, ".imm"},     act.imm,      exp.imm);
        chk({t, ".pc"},      act.pc,       exp.pc);
        chk({t, ".fmt"},     64'(act.fmt), 64'(exp.fmt));
        chk({t, ".illegal"}, 64'(act.ill), 64'(exp.ill));
    endtask

    task automatic check_outputs();
        obs_t e, z;
        chk("a.out_valid", 64'(a_out_valid), 64'(m_vld));
        chk("b.out_valid", 64'(b_out_valid), 64'(m_vld));
        chk("a.dec_count", 64'(a_cnt), 64'(m_cnt % 65536));
        chk("b.dec_count", 64'(b_cnt), 64'(m_cnt % 16));
        if (m_vld) begin
            e = ref_decode(m_instr, m_pc);
            cmp_obs("a", obs_a(), narrow(e));
            cmp_obs("b", obs_b(), e);
        end else if (m_fresh) begin
            z = '{op: 7'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7: 7'd0,
                  imm: 64'd0, pc: 64'd0, fmt: 3'd7, ill: 1'b0};
            cmp_obs("a.rst", obs_a(), z);
            cmp_obs("b.rst", obs_b(), z);
        end
    endtask

    // One clock: inputs are already driven; check in_ready, advance model, check outputs.
    task automatic tick();
        bit   rdy;
        obs_t held;
        #1;
        rdy = (!m_vld || out_ready) && !flush;
        if (rst_n) begin
            chk("a.in_ready", 64'(a_in_ready), 64'(rdy));
            chk("b.in_ready", 64'(b_in_ready), 64'(rdy));
        end
        @(posedge clk);
        if (!rst_n) begin
            m_vld = 1'b0;
            m_cnt = 0;
            m_fresh = 1'b1;
        end else begin
            held = ref_decode(m_instr, m_pc);
            if (m_vld && out_ready && !flush && !held.ill) m_cnt++;
            if (flush) m_vld = 1'b0;
            else if (in_valid && rdy) begin
                m_vld = 1'b1;
                m_instr = in_instr;
                m_pc = in_pc64;
                m_fresh = 1'b0;
            end else if (out_ready) m_vld = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        r = $urandom();
        if ($urandom_range(0, 9) < 8) return {r[31:7], ops[$urandom_range(0, 10)]};
        return r;
    endfunction

    initial begin
        vec_t        vt [11];
        obs_t        e;
        int unsigned c0;

        vt[0]  = '{32'hFFF10093, 3'd1, 5'd1,  5'd2, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[1]  = '{32'hFE000EE3, 3'd3, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vt[2]  = '{32'h123452B7, 3'd4, 5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_1234_5000, 1'b0};
        vt[3]  = '{32'h00000000, 3'd7, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 64'h0,                   1'b1};
        vt[4]  = '{32'h402081B3, 3'd0, 5'd3,  5'd1, 5'd2, 3'd0, 7'h20, 64'h0,                   1'b0};
        vt[5]  = '{32'h00512423, 3'd2, 5'd0,  5'd2, 5'd5, 3'd2, 7'h00, 64'h8,                   1'b0};
        vt[6]  = '{32'hFF9FF0EF, 3'd5, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
        vt[7]  = '{32'h80000517, 3'd4, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_8000_0000, 1'b0};
        vt[8]  = '{32'hFFF10090, 3'd7, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 64'h0,                   1'b1};
        vt[9]  = '{32'hFFC3A303, 3'd1, 5'd6,  5'd7, 5'd0, 3'd2, 7'h00, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vt[10] = '{32'h00000073, 3'd1, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 64'h0,                   1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc64 = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("rst.a.in_ready", 64'(a_in_ready), 64'd1);
        rst_n = 1'b1;

        // Table vectors, back-to-back at full throughput.
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_instr = vt[i].instr;
            in_pc64 = {$urandom(), $urandom()};
            tick();
            e = '{op: vt[i].instr[6:0], rd: vt[i].rd, rs1: vt[i].rs1, rs2: vt[i].rs2,
                  f3: vt[i].f3, f7: vt[i].f7, imm: vt[i].imm, pc: in_pc64,
                  fmt: vt[i].fmt, ill: vt[i].ill};
            cmp_obs($sformatf("vec%0d.b", i), obs_b(), e);
            cmp_obs($sformatf("vec%0d.a", i), obs_a(), narrow(e));
        end
        in_valid = 1'b0;
        tick();

        // Stall: A held for 3 cycles while B is offered, then A,B back-to-back.
        c0 = m_cnt;
        in_valid = 1'b1; in_instr = 32'hFFF10093; out_ready = 1'b0;
        tick();
        in_instr = 32'h123452B7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.in_ready", 64'(a_in_ready), 64'd0);
            chk("stall.a_imm", 64'(a_imm), 64'hFFFF_FFFF);
            chk("stall.a_rd", 64'(a_rd), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("b2b.a_imm", 64'(a_imm), 64'h1234_5000);
        chk("b2b.a_valid", 64'(a_out_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("stall.count", 64'(a_cnt), 64'((c0 + 2) % 65536));

        // Illegal word does not count.
        c0 = m_cnt;
        in_valid = 1'b1; in_instr = 32'h0;
        tick();
        chk("illegal.flag", 64'(a_ill), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("illegal.count", 64'(a_cnt), 64'(c0 % 65536));

        // Flush a stalled bundle.
        c0 = m_cnt;
        in_valid = 1'b1; in_instr = 32'h402081B3; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        tick();
        chk("flush.valid", 64'(a_out_valid), 64'd0);
        chk("flush.count", 64'(a_cnt), 64'(c0 % 65536));
        flush = 1'b0;

        // 16 legal transfers wrap the 4-bit counter back to its start value.
        c0 = m_cnt;
        in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h00000073;
        repeat (16) tick();
        in_valid = 1'b0;
        tick();
        chk("wrap.b_count", 64'(b_cnt), 64'(c0 % 16));
        chk("wrap.a_count", 64'(a_cnt), 64'((c0 + 16) % 65536));

        // Reset while a bundle is stalled, with accept and flush also requested.
        in_valid = 1'b1; in_instr = 32'hFF9FF0EF; out_ready = 1'b0;
        tick();
        rst_n = 1'b0; flush = 1'b1;
        tick();
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst.stall.in_ready", 64'(a_in_ready), 64'd1);
        chk("rst.stall.fmt", 64'(a_fmt), 64'd7);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_instr  = rand_instr();
            in_pc64   = {$urandom(), $urandom()};
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
